// File: rtl/sram_wr_seg_if.sv
// Ingress channel, allocator, SRAM write and descriptor signals of the
// multi-channel SRAM write segmenter.
interface sram_wr_seg_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int DES_W  = 4,
  parameter int PRI_W  = 3,
  parameter int LEN_W  = 7
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_eop;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH*DES_W-1:0]  ch_des;
  logic [NUM_CH*PRI_W-1:0]  ch_pri;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     base_valid;
  logic [ADDR_W-1:0]        base_addr;
  logic                     base_ready;
  logic                     sram_we;
  logic [ADDR_W-1:0]        sram_addr;
  logic [DATA_W-1:0]        sram_wdata;
  logic                     desc_valid;
  logic                     desc_ready;
  logic [DES_W-1:0]         desc_des;
  logic [PRI_W-1:0]         desc_pri;
  logic [ADDR_W-1:0]        desc_addr;
  logic [LEN_W-1:0]         desc_len;
  logic                     busy;
  logic                     err_ovf;

  modport slave (
    input  ch_valid, ch_eop, ch_data, ch_des, ch_pri, base_valid, base_addr, desc_ready,
    output ch_ready, base_ready, sram_we, sram_addr, sram_wdata,
           desc_valid, desc_des, desc_pri, desc_addr, desc_len, busy, err_ovf
  );

  modport master (
    output ch_valid, ch_eop, ch_data, ch_des, ch_pri, base_valid, base_addr, desc_ready,
    input  ch_ready, base_ready, sram_we, sram_addr, sram_wdata,
           desc_valid, desc_des, desc_pri, desc_addr, desc_len, busy, err_ovf
  );
endinterface

// File: rtl/sram_wr_seg.sv
// Round-robin multi-channel SRAM write segmenter: one packet at a time is
// written at allocator-supplied addresses, then described to the enqueue logic.
module sram_wr_seg #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int DES_W  = 4,
  parameter int PRI_W  = 3,
  parameter int LEN_W  = 7
) (
  input logic          clk,
  input logic          rst,
  sram_wr_seg_if.slave bus
);

  localparam int          GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned NCH     = NUM_CH;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [2:0] {ST_IDLE, ST_ALLOC, ST_XFER, ST_DESC, ST_DRAIN} state_t;

  state_t            r_state, w_next;
  logic [GW-1:0]     r_grant, r_last, w_pick, w_idx;
  logic              w_any;
  logic [ADDR_W-1:0] r_cur_addr, r_start_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic [DES_W-1:0]  r_des;
  logic [PRI_W-1:0]  r_pri;
  logic              r_trunc;
  logic              r_we, r_ovf;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic [NUM_CH-1:0] w_ready;
  logic              w_sel_valid, w_sel_eop, w_accept, w_cnt_full;
  logic [DATA_W-1:0] w_sel_data;
  logic [DES_W-1:0]  w_sel_des;
  logic [PRI_W-1:0]  w_sel_pri;

  assign w_sel_valid = bus.ch_valid[r_grant];
  assign w_sel_eop   = bus.ch_eop[r_grant];
  assign w_sel_data  = bus.ch_data[32'(r_grant)*DATA_W +: DATA_W];
  assign w_sel_des   = bus.ch_des[32'(r_grant)*DES_W +: DES_W];
  assign w_sel_pri   = bus.ch_pri[32'(r_grant)*PRI_W +: PRI_W];
  assign w_accept    = w_sel_valid && ((r_state == ST_XFER) || (r_state == ST_DRAIN));
  assign w_cnt_full  = (r_cnt == LEN_MAX - 1'b1);

  // First requesting channel after the last grant, wrapping past NUM_CH-1.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    w_idx  = r_last;
    for (int unsigned i = 1; i <= NCH; i++) begin
      if (32'(r_last) + i >= NCH) w_idx = GW'(32'(r_last) + i - NCH);
      else                        w_idx = GW'(32'(r_last) + i);
      if (!w_any && bus.ch_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if ((r_state == ST_XFER) || (r_state == ST_DRAIN)) w_ready[r_grant] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next = ST_ALLOC;
      ST_ALLOC: if (bus.base_valid) w_next = ST_XFER;
      ST_XFER:  if (w_accept && (w_sel_eop || w_cnt_full)) w_next = ST_DESC;
      ST_DESC:  if (bus.desc_ready) w_next = r_trunc ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (w_accept && w_sel_eop) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant      <= '0;
      r_last       <= GW'(NUM_CH - 1);
      r_cur_addr   <= '0;
      r_start_addr <= '0;
      r_cnt        <= '0;
      r_des        <= '0;
      r_pri        <= '0;
      r_trunc      <= 1'b0;
      r_we         <= 1'b0;
      r_ovf        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_we    <= 1'b0;
      r_ovf   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
          end
        end
        ST_ALLOC: begin
          if (bus.base_valid) begin
            r_cur_addr   <= bus.base_addr;
            r_start_addr <= bus.base_addr;
            r_cnt        <= '0;
          end
        end
        ST_XFER: begin
          if (w_accept) begin
            if (r_cnt == '0) begin
              r_des <= w_sel_des;
              r_pri <= w_sel_pri;
            end
            r_we       <= 1'b1;
            r_waddr    <= r_cur_addr;
            r_wdata    <= w_sel_data;
            r_cur_addr <= r_cur_addr + 1'b1;
            r_cnt      <= r_cnt + 1'b1;
            // Full length without eop: keep this beat, drop the rest in DRAIN.
            if (!w_sel_eop && w_cnt_full) begin
              r_ovf   <= 1'b1;
              r_trunc <= 1'b1;
            end
          end
        end
        ST_DRAIN: if (w_accept && w_sel_eop) r_trunc <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ch_ready   = w_ready;
  assign bus.base_ready = (r_state == ST_ALLOC);
  assign bus.sram_we    = r_we;
  assign bus.sram_addr  = r_waddr;
  assign bus.sram_wdata = r_wdata;
  assign bus.err_ovf    = r_ovf;
  assign bus.desc_valid = (r_state == ST_DESC);
  assign bus.desc_des   = r_des;
  assign bus.desc_pri   = r_pri;
  assign bus.desc_addr  = r_start_addr;
  assign bus.desc_len   = r_cnt;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sram_wr_seg.sv
// Directed bench for sram_wr_seg: packet table plus round-robin, stall and
// mid-packet reset sequences, with write and descriptor scoreboards.
module tb_sram_wr_seg;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;
  localparam int DES_W  = 4;
  localparam int PRI_W  = 3;
  localparam int LEN_W  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_wr_seg_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                   .DES_W(DES_W), .PRI_W(PRI_W), .LEN_W(LEN_W)) bus ();

  sram_wr_seg #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                .DES_W(DES_W), .PRI_W(PRI_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [15:0] addr; logic [63:0] data; logic ovf; } wr_t;
  typedef struct { logic [3:0] des; logic [2:0] pri; logic [15:0] addr; logic [6:0] len; } desc_t;
  typedef struct { int ch; int n; int des; int pri; logic [15:0] base; int exp_len; bit exp_ovf; } vec_t;

  wr_t         wr_q[$];
  desc_t       desc_q[$];
  logic [15:0] base_q[$];
  logic        base_en  = 1'b1;
  logic        desc_rdy = 1'b1;

  assign bus.desc_ready = desc_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_data(input int ch, input int tag, input int idx);
    return {24'hABCDEF, 8'(ch), 16'(tag), 16'(idx)};
  endfunction

  task automatic expect_pkt(input int ch, input int tag, input int des, input int pri,
                            input logic [15:0] base, input int len, input bit ovf);
    wr_t w;
    desc_t d;
    for (int i = 0; i < len; i++) begin
      w.addr = base + 16'(i);
      w.data = mk_data(ch, tag, i);
      w.ovf  = ovf && (i == len - 1);
      wr_q.push_back(w);
    end
    d.des = 4'(des); d.pri = 3'(pri); d.addr = base; d.len = 7'(len);
    desc_q.push_back(d);
    base_q.push_back(base);
  endtask

  task automatic send_pkt(input int ch, input int tag, input int n, input int des, input int pri);
    int  i = 0;
    int  guard = 0;
    logic acc;
    bus.ch_des[ch*DES_W +: DES_W] = DES_W'(des);
    bus.ch_pri[ch*PRI_W +: PRI_W] = PRI_W'(pri);
    while (i < n) begin
      bus.ch_valid[ch] = 1'b1;
      bus.ch_eop[ch]   = (i == n - 1);
      bus.ch_data[ch*DATA_W +: DATA_W] = mk_data(ch, tag, i);
      @(negedge clk);
      acc = bus.ch_ready[ch];
      @(posedge clk); #1;
      if (acc) i++;
      else begin
        guard++;
        if (guard > 2000) begin
          chk("send_timeout", 64'(i), 64'(n));
          break;
        end
      end
    end
    bus.ch_valid[ch] = 1'b0;
    bus.ch_eop[ch]   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((bus.busy || wr_q.size() > 0 || desc_q.size() > 0) && c < 600);
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
    chk({name, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    chk({name, "_desc_left"}, 64'(desc_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Allocator model: offers queued base addresses, pops on handshake.
  bit take;
  initial begin
    bus.base_valid = 1'b0;
    bus.base_addr  = '0;
    forever begin
      @(negedge clk);
      take = bus.base_valid && bus.base_ready;
      @(posedge clk); #1;
      if (take && base_q.size() > 0) void'(base_q.pop_front());
      bus.base_valid = base_en && (base_q.size() > 0);
      bus.base_addr  = (base_q.size() > 0) ? base_q[0] : 16'h0;
    end
  end

  // Write/descriptor scoreboard, sampled on the falling edge.
  logic  prev_dv = 1'b0;
  wr_t   mw;
  desc_t md;
  initial begin
    forever begin
      @(negedge clk);
      chk("ready_onehot0", 64'($onehot0(bus.ch_ready)), 64'd1);
      if (bus.sram_we) begin
        chk("write_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          mw = wr_q.pop_front();
          chk("sram_addr", 64'(bus.sram_addr), 64'(mw.addr));
          chk("sram_wdata", bus.sram_wdata, mw.data);
          chk("err_ovf", 64'(bus.err_ovf), 64'(mw.ovf));
        end
      end else begin
        chk("idle_sram_addr", 64'(bus.sram_addr), 64'd0);
        chk("idle_sram_wdata", bus.sram_wdata, 64'd0);
        chk("ovf_without_we", 64'(bus.err_ovf), 64'd0);
      end
      if (bus.desc_valid && !prev_dv) chk("desc_with_last_we", 64'(bus.sram_we), 64'd1);
      if (bus.desc_valid && bus.desc_ready) begin
        chk("desc_expected", 64'(desc_q.size() != 0), 64'd1);
        if (desc_q.size() != 0) begin
          md = desc_q.pop_front();
          chk("desc_des", 64'(bus.desc_des), 64'(md.des));
          chk("desc_pri", 64'(bus.desc_pri), 64'(md.pri));
          chk("desc_addr", 64'(bus.desc_addr), 64'(md.addr));
          chk("desc_len", 64'(bus.desc_len), 64'(md.len));
        end
      end
      prev_dv = bus.desc_valid;
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_sram_we"}, 64'(bus.sram_we), 64'd0);
    chk({name, "_sram_addr"}, 64'(bus.sram_addr), 64'd0);
    chk({name, "_sram_wdata"}, bus.sram_wdata, 64'd0);
    chk({name, "_ch_ready"}, 64'(bus.ch_ready), 64'd0);
    chk({name, "_base_ready"}, 64'(bus.base_ready), 64'd0);
    chk({name, "_desc_valid"}, 64'(bus.desc_valid), 64'd0);
    chk({name, "_desc_len"}, 64'(bus.desc_len), 64'd0);
    chk({name, "_desc_addr"}, 64'(bus.desc_addr), 64'd0);
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
    chk({name, "_err_ovf"}, 64'(bus.err_ovf), 64'd0);
  endtask

  vec_t vecs[5];
  int   got, guard, c;
  logic acc;

  initial begin
    vecs[0] = '{ch: 1, n: 3,   des: 5,  pri: 2, base: 16'h0100, exp_len: 3,   exp_ovf: 1'b0};
    vecs[1] = '{ch: 3, n: 4,   des: 9,  pri: 7, base: 16'hFFFE, exp_len: 4,   exp_ovf: 1'b0};
    vecs[2] = '{ch: 2, n: 130, des: 3,  pri: 1, base: 16'h2000, exp_len: 127, exp_ovf: 1'b1};
    vecs[3] = '{ch: 0, n: 1,   des: 15, pri: 0, base: 16'h0040, exp_len: 1,   exp_ovf: 1'b0};
    vecs[4] = '{ch: 1, n: 127, des: 1,  pri: 4, base: 16'h3000, exp_len: 127, exp_ovf: 1'b0};

    bus.ch_valid = '0;
    bus.ch_eop   = '0;
    bus.ch_data  = '0;
    bus.ch_des   = '0;
    bus.ch_pri   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin from reset: ch0 first, then ch2; next time ch0 again.
    expect_pkt(0, 1, 4, 1, 16'h1000, 2, 1'b0);
    expect_pkt(2, 2, 8, 6, 16'h1100, 2, 1'b0);
    fork
      send_pkt(0, 1, 2, 4, 1);
      send_pkt(2, 2, 2, 8, 6);
    join
    wait_idle("rr1");
    expect_pkt(0, 3, 4, 1, 16'h1200, 2, 1'b0);
    expect_pkt(2, 4, 8, 6, 16'h1300, 2, 1'b0);
    fork
      send_pkt(0, 3, 2, 4, 1);
      send_pkt(2, 4, 2, 8, 6);
    join
    wait_idle("rr2");

    foreach (vecs[k]) begin
      expect_pkt(vecs[k].ch, 10 + k, vecs[k].des, vecs[k].pri, vecs[k].base,
                 vecs[k].exp_len, vecs[k].exp_ovf);
      send_pkt(vecs[k].ch, 10 + k, vecs[k].n, vecs[k].des, vecs[k].pri);
      wait_idle($sformatf("vec%0d", k));
    end

    // Allocator and descriptor stalls.
    base_en  = 1'b0;
    desc_rdy = 1'b0;
    @(posedge clk); #1;
    expect_pkt(1, 20, 6, 3, 16'h0500, 3, 1'b0);
    fork
      send_pkt(1, 20, 3, 6, 3);
      begin
        c = 0;
        do begin @(negedge clk); c++; end while (!bus.busy && c < 20);
        chk("stall_grant", 64'(bus.busy), 64'd1);
        repeat (5) begin
          @(negedge clk);
          chk("alloc_stall_ch_ready", 64'(bus.ch_ready), 64'd0);
          chk("alloc_stall_base_ready", 64'(bus.base_ready), 64'd1);
        end
        @(posedge clk); #1;
        base_en = 1'b1;
        c = 0;
        do begin @(negedge clk); c++; end while (!bus.desc_valid && c < 50);
        chk("stall_desc_valid", 64'(bus.desc_valid), 64'd1);
        repeat (4) begin
          @(negedge clk);
          chk("desc_stall_valid", 64'(bus.desc_valid), 64'd1);
          chk("desc_stall_des", 64'(bus.desc_des), 64'd6);
          chk("desc_stall_pri", 64'(bus.desc_pri), 64'd3);
          chk("desc_stall_addr", 64'(bus.desc_addr), 64'h0500);
          chk("desc_stall_len", 64'(bus.desc_len), 64'd3);
          chk("desc_stall_ch_ready", 64'(bus.ch_ready), 64'd0);
          chk("desc_stall_we", 64'(bus.sram_we), 64'd0);
        end
        @(posedge clk); #1;
        desc_rdy = 1'b1;
      end
    join
    wait_idle("stall");

    // Reset after two beats of a ch1 packet: writes seen, no descriptor.
    base_q.push_back(16'h0700);
    mw.addr = 16'h0700; mw.data = mk_data(1, 30, 0); mw.ovf = 1'b0; wr_q.push_back(mw);
    mw.addr = 16'h0701; mw.data = mk_data(1, 30, 1); mw.ovf = 1'b0; wr_q.push_back(mw);
    got = 0;
    guard = 0;
    while (got < 2 && guard < 50) begin
      bus.ch_valid[1] = 1'b1;
      bus.ch_eop[1]   = 1'b0;
      bus.ch_data[1*DATA_W +: DATA_W] = mk_data(1, 30, got);
      @(negedge clk);
      acc = bus.ch_ready[1];
      @(posedge clk); #1;
      if (acc) got++;
      guard++;
    end
    chk("pre_reset_beats", 64'(got), 64'd2);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    bus.ch_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("reset_write_drained", 64'(wr_q.size()), 64'd0);

    // After reset ch0 beats ch3 even though ch1 was the last grant.
    expect_pkt(0, 31, 2, 5, 16'h0800, 2, 1'b0);
    expect_pkt(3, 32, 11, 0, 16'h0900, 2, 1'b0);
    fork
      send_pkt(0, 31, 2, 2, 5);
      send_pkt(3, 32, 2, 11, 0);
    join
    wait_idle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
